// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - Shared constants and state type for the 7-segment count decoder.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam int CNT_W = 3;

  // Segment order {a,b,c,d,e,f,g}, active-high.
  localparam logic [SEG_W-1:0] SEG_CODE_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_CODE_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_CODE_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_CODE_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_CODE_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_CODE_5 = 7'b1011011;

  typedef enum logic [1:0] {
    S_INIT,
    S_TRACK,
    S_ERR
  } seg_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - Combinational 7-segment pattern to count 0..5 decoder.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic             legal,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    legal = 1'b1;
    count = '0;
    case (pattern)
      SEG_CODE_0: count = 3'd0;
      SEG_CODE_1: count = 3'd1;
      SEG_CODE_2: count = 3'd2;
      SEG_CODE_3: count = 3'd3;
      SEG_CODE_4: count = 3'd4;
      SEG_CODE_5: count = 3'd5;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_count_decoder.sv
// rtl/seg_count_decoder.sv - Debounces a 7-segment bus and decodes it to a count with change events.
// Optional SEG_ACTIVE_LOW_EN: invert segs_i before sampling (common-anode display).
module seg_count_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEG_W-1:0]    segs_i,
  output logic [CNT_W-1:0]    count_o,
  output logic                count_valid_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [CNT_W-1:0]    evt_count_o,
  output logic                evt_ovr_o,
  output logic                err_o,
  output logic [ERRCNT_W-1:0] err_cnt_o
);

  localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] STAB_LAST = 4'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0] segs_s;
  logic [SEG_W-1:0] segs_q;
  logic [3:0]       stab_cnt;
  seg_state_t       state;
  logic             dec_legal;
  logic [CNT_W-1:0] dec_count;
  logic             commit;
  logic             raise;

`ifdef SEG_ACTIVE_LOW_EN
  assign segs_s = ~segs_i;
`else
  assign segs_s = segs_i;
`endif

  seg_pattern_decode u_decode (
    .pattern (segs_q),
    .legal   (dec_legal),
    .count   (dec_count)
  );

  // Commit exactly once per stable episode, on the edge the counter reaches STABLE_CYCLES.
  assign commit = (segs_s == segs_q) && (stab_cnt == STAB_LAST);
  assign raise  = commit && dec_legal && (!count_valid_o || (dec_count != count_o));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs_q        <= '0;
      stab_cnt      <= '0;
      state         <= S_INIT;
      count_o       <= '0;
      count_valid_o <= 1'b0;
      evt_valid_o   <= 1'b0;
      evt_count_o   <= '0;
      evt_ovr_o     <= 1'b0;
      err_o         <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      if (segs_s != segs_q) begin
        segs_q   <= segs_s;
        stab_cnt <= '0;
      end else if (stab_cnt < STAB_MAX) begin
        stab_cnt <= stab_cnt + 4'd1;
      end

      if (commit) begin
        if (dec_legal) begin
          state         <= S_TRACK;
          count_o       <= dec_count;
          count_valid_o <= 1'b1;
          err_o         <= 1'b0;
        end else if (state != S_ERR) begin
          state <= S_ERR;
          err_o <= 1'b1;
          if (err_cnt_o != '1) begin
            err_cnt_o <= err_cnt_o + 1'b1;
          end
        end
      end

      // A new raise always wins over acceptance on the same edge.
      if (raise) begin
        evt_valid_o <= 1'b1;
        evt_count_o <= dec_count;
        if (evt_valid_o && !evt_ready_i) begin
          evt_ovr_o <= 1'b1;
        end
      end else if (evt_valid_o && evt_ready_i) begin
        evt_valid_o <= 1'b0;
      end
    end
  end

endmodule
